// File: rtl/s1423_resp_compactor.sv
// Response compactor: folds a stream of captured n70 bits into a MISR signature
// and counts mismatches against the expected values over a run of CNT_LIM vectors.
module s1423_resp_compactor #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic             ABORT,
  input  logic [7:0]       CNT_LIM,
  input  logic             VLD,
  input  logic             N70,
  input  logic             EXP,
  output logic             RDY,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [SIG_W-1:0] SIG,
  output logic [7:0]       ERRCNT
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] vcnt, lim;
  logic       load, accept, last;

  // ABORT dominates both START and a sample presented in the same cycle
  assign load   = (state != S_RUN) && START && !ABORT;
  assign accept = (state == S_RUN) && VLD && !ABORT;
  assign last   = (vcnt + 8'd1) == lim;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (load) state_nx = (CNT_LIM != 8'd0) ? S_RUN : S_DONE;
      S_RUN: begin
        if (ABORT)            state_nx = S_IDLE;
        else if (accept && last) state_nx = S_DONE;
      end
      S_DONE: begin
        if (ABORT)     state_nx = S_IDLE;
        else if (load) state_nx = (CNT_LIM != 8'd0) ? S_RUN : S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      SIG    <= SEED;
      ERRCNT <= 8'd0;
      vcnt   <= 8'd0;
      lim    <= 8'd0;
    end else if (load) begin
      SIG    <= SEED;
      ERRCNT <= 8'd0;
      vcnt   <= 8'd0;
      lim    <= CNT_LIM;
    end else if (accept) begin
      SIG  <= {SIG[SIG_W-2:0], 1'b0} ^ ((SIG[SIG_W-1] ^ N70) ? POLY : '0);
      vcnt <= vcnt + 8'd1;
      if ((N70 != EXP) && (ERRCNT != 8'hFF)) ERRCNT <= ERRCNT + 8'd1;
    end
  end

  assign RDY  = (state == S_RUN);
  assign BUSY = (state == S_RUN);
  assign DONE = (state == S_DONE);
  assign FAIL = (state == S_DONE) && (ERRCNT != 8'd0);

endmodule

// File: doc/s1423_resp_compactor.md
S1423_RESP_COMPACTOR -- requirements
Module: s1423_resp_compactor

Interface
REQ-001 SHALL have parameter SIG_W, 16, signature register width.
REQ-002 SHALL have parameter POLY, 16'h1021, MISR feedback polynomial.
REQ-003 SHALL have parameter SEED, 16'hFFFF, signature value loaded at run start and at reset.
REQ-004 SHALL have port CK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port START  input  1  run request pulse.
REQ-007 SHALL have port ABORT  input  1  terminate current run.
REQ-008 SHALL have port CNT_LIM  input  8  vectors per run, sampled on accepted START.
REQ-009 SHALL have port VLD  input  1  response sample valid from the combinational n70 stage.
REQ-010 SHALL have port N70  input  1  captured n70 response bit.
REQ-011 SHALL have port EXP  input  1  expected n70 value for the same vector.
REQ-012 SHALL have port RDY  output  1  sample accepted this cycle when VLD=1.
REQ-013 SHALL have port BUSY  output  1  high in RUN.
REQ-014 SHALL have port DONE  output  1  high in DONE.
REQ-015 SHALL have port FAIL  output  1  ERRCNT nonzero, valid while DONE.
REQ-016 SHALL have port SIG  output  SIG_W  MISR signature.
REQ-017 SHALL have port ERRCNT  output  8  mismatch count.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; RDY=BUSY=(state==RUN), DONE=(state==DONE), all registered-state decodes.
REQ-019 IDLE or DONE, START=1, ABORT=0: next state RUN if CNT_LIM!=0, else DONE; same edge loads SIG=SEED, ERRCNT=0, vector counter VCNT=0, LIM=CNT_LIM.
REQ-020 RUN: START ignored; accept occurs on cycle with VLD=1 (RDY=1).
REQ-021 On accept: SIG <= {SIG[SIG_W-2:0],0} XOR (POLY if SIG[SIG_W-1] XOR N70 else 0); single-cycle update, zero latency to SIG on next edge.
REQ-022 On accept with N70!=EXP: ERRCNT increments, saturating at 255 (no wrap).
REQ-023 On accept: VCNT increments; if VCNT+1==LIM, next state DONE (DONE high the cycle after the last accept).
REQ-024 No accept (VLD=0): SIG, ERRCNT, VCNT hold.
REQ-025 ABORT=1 in RUN: next state IDLE; SIG and ERRCNT hold last values; a VLD on that cycle SHALL NOT be accepted.
REQ-026 ABORT and START same cycle: ABORT wins; state IDLE (from RUN or DONE), no load.
REQ-027 ABORT in DONE: next state IDLE, results held; ABORT in IDLE: no effect.
REQ-028 DONE holds until START (new run) or ABORT; SIG/ERRCNT/FAIL stable while DONE.
REQ-029 FAIL SHALL equal (ERRCNT!=0) AND DONE; 0 in other states.
REQ-030 VLD in IDLE or DONE SHALL be ignored (RDY=0, no update).

Reset
REQ-031 RN low SHALL immediately force state IDLE, SIG=SEED, ERRCNT=0, VCNT=0, LIM=0; outputs RDY=BUSY=DONE=FAIL=0.
REQ-032 RN asserted mid-RUN SHALL discard the run; after release block waits in IDLE for START.
REQ-033 Release of RN SHALL take effect on first CK edge with RN high; no state change earlier.

Verification
REQ-034 Reset, START with CNT_LIM=1, VLD=1 N70=0 EXP=0 -> SIG=16'hEFDF, ERRCNT=0, DONE=1 next cycle, FAIL=0.
REQ-035 START CNT_LIM=1, VLD=1 N70=1 EXP=0 -> SIG=16'hFFFE, ERRCNT=1, DONE=1, FAIL=1.
REQ-036 START CNT_LIM=0 -> DONE=1 one cycle later, BUSY never high, SIG=16'hFFFF, ERRCNT=0.
REQ-037 START CNT_LIM=255, 255 accepts all mismatching, VLD gaps inserted -> ERRCNT saturates 255, DONE after 255th accept only, SIG matches reference MISR model.
REQ-038 RUN with CNT_LIM=10, ABORT+START+VLD same cycle after 3 accepts -> IDLE, no accept, ERRCNT/SIG hold 3-vector values; RN pulse mid-RUN -> all outputs at reset values asynchronously.
